// File: rtl/multi_alarm_clock.sv
// Multi-alarm BCD time-of-day clock with per-alarm DISARMED/ARMED/RINGING FSMs.
// Define ALARM_SNOOZE_EN to add the SNOOZED state and its per-alarm countdown.
module multi_alarm_clock #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5,
    localparam int unsigned SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            H_in1,
    input  logic [3:0]            H_in0,
    input  logic [3:0]            M_in1,
    input  logic [3:0]            M_in0,
    input  logic                  LD_time,
    input  logic                  LD_alarm,
    input  logic [SEL_W-1:0]      AL_sel,
    input  logic                  AL_clr,
    input  logic                  STOP_al,
    input  logic                  SNOOZE,
    output logic [NUM_ALARMS-1:0] alarm,
    output logic                  alarm_any,
    output logic                  tick,
    output logic [1:0]            H_out1,
    output logic [3:0]            H_out0,
    output logic [3:0]            M_out1,
    output logic [3:0]            M_out0,
    output logic [3:0]            S_out1,
    output logic [3:0]            S_out0
);

    localparam int unsigned CNT_W  = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned RING_W = 8;
    localparam int unsigned HM_W   = 14;

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CLK_FREQ - 1);
    localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SEC);

    localparam logic [1:0] ST_DISARMED = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_RINGING  = 2'd2;
`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] ST_SNOOZED  = 2'd3;
    localparam int unsigned SNZ_W      = 12;
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MIN * 60);
`else
    logic unused_snooze;
    assign unused_snooze = SNOOZE | (SNOOZE_MIN == 0);
`endif

    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  in_valid;
    logic                  ld_time_ok;
    logic                  ld_alarm_ok;
    logic                  time_adv;
    logic [HM_W-1:0]       in_hm;
    logic [HM_W-1:0]       inc_hm;
    logic [1:0]            inc_h1;
    logic [3:0]            inc_h0;
    logic [3:0]            inc_m1;
    logic [3:0]            inc_m0;
    logic [3:0]            inc_s1;
    logic [3:0]            inc_s0;
    logic                  inc_at_min;
    logic [NUM_ALARMS-1:0] alarm_next;

    // Loaded hh:mm must be a legal 24-hour BCD time.
    assign in_valid = ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)))
                      && (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9);
    assign ld_time_ok  = LD_time && in_valid;
    assign ld_alarm_ok = LD_alarm && in_valid;
    assign in_hm       = {H_in1, H_in0, M_in1, M_in0};

    assign cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    // A load wins over the tick, so only unloaded ticks advance time or fire alarms.
    assign time_adv = tick && !ld_time_ok;

    // Current time plus one second, BCD with full carry chain.
    always_comb begin
        inc_h1 = H_out1;
        inc_h0 = H_out0;
        inc_m1 = M_out1;
        inc_m0 = M_out0;
        inc_s1 = S_out1;
        inc_s0 = S_out0 + 4'd1;
        if (S_out0 == 4'd9) begin
            inc_s0 = 4'd0;
            inc_s1 = S_out1 + 4'd1;
            if (S_out1 == 4'd5) begin
                inc_s1 = 4'd0;
                inc_m0 = M_out0 + 4'd1;
                if (M_out0 == 4'd9) begin
                    inc_m0 = 4'd0;
                    inc_m1 = M_out1 + 4'd1;
                    if (M_out1 == 4'd5) begin
                        inc_m1 = 4'd0;
                        if ((H_out1 == 2'd2) && (H_out0 == 4'd3)) begin
                            inc_h1 = 2'd0;
                            inc_h0 = 4'd0;
                        end else if (H_out0 == 4'd9) begin
                            inc_h0 = 4'd0;
                            inc_h1 = H_out1 + 2'd1;
                        end else begin
                            inc_h0 = H_out0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    assign inc_hm     = {inc_h1, inc_h0, inc_m1, inc_m0};
    assign inc_at_min = (inc_s1 == 4'd0) && (inc_s0 == 4'd0);

    // Prescaler, tick pulse and time-of-day registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            tick   <= 1'b0;
            H_out1 <= 2'd0;
            H_out0 <= 4'd0;
            M_out1 <= 4'd0;
            M_out0 <= 4'd0;
            S_out1 <= 4'd0;
            S_out0 <= 4'd0;
        end else if (ld_time_ok) begin
            cnt    <= '0;
            tick   <= (CLK_FREQ == 1);
            H_out1 <= H_in1;
            H_out0 <= H_in0;
            M_out1 <= M_in1;
            M_out0 <= M_in0;
            S_out1 <= 4'd0;
            S_out0 <= 4'd0;
        end else begin
            cnt  <= cnt_next;
            tick <= (cnt_next == CNT_MAX);
            if (tick) begin
                H_out1 <= inc_h1;
                H_out0 <= inc_h0;
                M_out1 <= inc_m1;
                M_out0 <= inc_m0;
                S_out1 <= inc_s1;
                S_out0 <= inc_s0;
            end
        end
    end

    for (genvar i = 0; i < int'(NUM_ALARMS); i++) begin : g_alarm
        logic [1:0]        st;
        logic [1:0]        st_n;
        logic [RING_W-1:0] ring;
        logic [RING_W-1:0] ring_n;
        logic [HM_W-1:0]   al_hm;
        logic              sel_hit;
        logic              clr_hit;
        logic              ld_hit;
        logic              trig;
        logic              stoppable;
`ifdef ALARM_SNOOZE_EN
        logic [SNZ_W-1:0]  snz;
        logic [SNZ_W-1:0]  snz_n;

        assign stoppable = (st == ST_RINGING) || (st == ST_SNOOZED);
`else
        assign stoppable = (st == ST_RINGING);
`endif

        // Out-of-range selects match no alarm and are therefore ignored.
        assign sel_hit = (AL_sel == SEL_W'(i));
        assign clr_hit = sel_hit && AL_clr;
        assign ld_hit  = sel_hit && ld_alarm_ok && !AL_clr;
        assign trig    = time_adv && inc_at_min && (inc_hm == al_hm);

        // Next-state: select > stop > snooze > trigger/timeout.
        always_comb begin
            st_n   = st;
            ring_n = ring;
`ifdef ALARM_SNOOZE_EN
            snz_n  = snz;
`endif
            if (clr_hit) begin
                st_n   = ST_DISARMED;
                ring_n = '0;
`ifdef ALARM_SNOOZE_EN
                snz_n  = '0;
`endif
            end else if (ld_hit || (STOP_al && stoppable)) begin
                st_n   = ST_ARMED;
                ring_n = '0;
`ifdef ALARM_SNOOZE_EN
                snz_n  = '0;
            end else if (SNOOZE && (st == ST_RINGING)) begin
                st_n   = ST_SNOOZED;
                ring_n = '0;
                snz_n  = SNZ_LOAD;
`endif
            end else begin
                case (st)
                    ST_ARMED: begin
                        if (trig) begin
                            st_n   = ST_RINGING;
                            ring_n = RING_LOAD;
                        end
                    end
                    ST_RINGING: begin
                        if (tick) begin
                            if (ring <= RING_W'(1)) begin
                                st_n   = ST_ARMED;
                                ring_n = '0;
                            end else begin
                                ring_n = ring - RING_W'(1);
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_SNOOZED: begin
                        if (tick) begin
                            if (snz <= SNZ_W'(1)) begin
                                st_n   = ST_RINGING;
                                ring_n = RING_LOAD;
                                snz_n  = '0;
                            end else begin
                                snz_n = snz - SNZ_W'(1);
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                st    <= ST_DISARMED;
                ring  <= '0;
                al_hm <= '0;
`ifdef ALARM_SNOOZE_EN
                snz   <= '0;
`endif
            end else begin
                st   <= st_n;
                ring <= ring_n;
`ifdef ALARM_SNOOZE_EN
                snz  <= snz_n;
`endif
                if (ld_hit) begin
                    al_hm <= in_hm;
                end
            end
        end

        assign alarm_next[i] = (st_n == ST_RINGING);
    end

    // Ringing flags registered from next state so they track RINGING exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm     <= '0;
            alarm_any <= 1'b0;
        end else begin
            alarm     <= alarm_next;
            alarm_any <= |alarm_next;
        end
    end

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed bench for multi_alarm_clock at CLK_FREQ=4, NUM_ALARMS=4, RING_SEC=3, SNOOZE_MIN=1.
// One second is exactly four clocks after a time load; expectations are hand-derived.
module tb_multi_alarm_clock;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  H_in1;
    logic [3:0]  H_in0;
    logic [3:0]  M_in1;
    logic [3:0]  M_in0;
    logic        LD_time;
    logic        LD_alarm;
    logic [1:0]  AL_sel;
    logic        AL_clr;
    logic        STOP_al;
    logic        SNOOZE;
    logic [3:0]  alarm;
    logic        alarm_any;
    logic        tick;
    logic [1:0]  H_out1;
    logic [3:0]  H_out0;
    logic [3:0]  M_out1;
    logic [3:0]  M_out0;
    logic [3:0]  S_out1;
    logic [3:0]  S_out0;
    logic [23:0] now_t;

    int n_vec = 0;
    int n_err = 0;

    multi_alarm_clock #(
        .CLK_FREQ   (4),
        .NUM_ALARMS (4),
        .RING_SEC   (3),
        .SNOOZE_MIN (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .LD_time   (LD_time),
        .LD_alarm  (LD_alarm),
        .AL_sel    (AL_sel),
        .AL_clr    (AL_clr),
        .STOP_al   (STOP_al),
        .SNOOZE    (SNOOZE),
        .alarm     (alarm),
        .alarm_any (alarm_any),
        .tick      (tick),
        .H_out1    (H_out1),
        .H_out0    (H_out0),
        .M_out1    (M_out1),
        .M_out0    (M_out0),
        .S_out1    (S_out1),
        .S_out0    (S_out0)
    );

    always #5 clk = ~clk;

    assign now_t = {2'b00, H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_hm(input logic [15:0] hm);
        H_in1 = hm[13:12];
        H_in0 = hm[11:8];
        M_in1 = hm[7:4];
        M_in0 = hm[3:0];
    endtask

    task automatic load_time(input logic [15:0] hm);
        set_hm(hm);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
    endtask

    task automatic load_alarm(input logic [1:0] sel, input logic [15:0] hm);
        set_hm(hm);
        AL_sel   = sel;
        LD_alarm = 1'b1;
        cyc(1);
        LD_alarm = 1'b0;
    endtask

    task automatic clr_alarm(input logic [1:0] sel);
        AL_sel = sel;
        AL_clr = 1'b1;
        cyc(1);
        AL_clr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(2);
        n_vec++;
        if (now_t !== 24'h000000) begin n_err++; $display("FAIL reset_time: got %h want %h", now_t, 24'h000000); end
        n_vec++;
        if (alarm !== 4'b0000 || alarm_any !== 1'b0 || tick !== 1'b0) begin
            n_err++; $display("FAIL reset_outs: got alarm=%b any=%b tick=%b want 0000/0/0", alarm, alarm_any, tick);
        end
        reset = 1'b0;
        cyc(3);
        n_vec++;
        if (tick !== 1'b1 || now_t !== 24'h000000) begin
            n_err++; $display("FAIL first_tick: got tick=%b time=%h want 1/000000", tick, now_t);
        end
        cyc(1);
        n_vec++;
        if (tick !== 1'b0 || now_t !== 24'h000001) begin
            n_err++; $display("FAIL first_sec: got tick=%b time=%h want 0/000001", tick, now_t);
        end
    endtask

    task automatic test_rollover;
        logic [23:0] exp_t;
        load_time(16'h2359);
        n_vec++;
        if (now_t !== 24'h235900) begin n_err++; $display("FAIL load_2359: got %h want %h", now_t, 24'h235900); end
        for (int k = 1; k <= 4; k++) begin
            cyc(4);
            exp_t = 24'h235900 + 24'(k);
            n_vec++;
            if (now_t !== exp_t) begin n_err++; $display("FAIL sec_step%0d: got %h want %h", k, now_t, exp_t); end
        end
        cyc(4 * 55);
        n_vec++;
        if (now_t !== 24'h235959) begin n_err++; $display("FAIL reach_235959: got %h want %h", now_t, 24'h235959); end
        cyc(3);
        n_vec++;
        if (tick !== 1'b1) begin n_err++; $display("FAIL wrap_tick: got %b want 1", tick); end
        cyc(1);
        n_vec++;
        if (now_t !== 24'h000000 || tick !== 1'b0) begin
            n_err++; $display("FAIL day_wrap: got %h tick=%b want 000000 tick=0", now_t, tick);
        end
    endtask

    task automatic test_alarm_ring;
        load_alarm(2'd2, 16'h0730);
        load_time(16'h0729);
        cyc(4 * 59);
        n_vec++;
        if (now_t !== 24'h072959 || alarm !== 4'b0000) begin
            n_err++; $display("FAIL pre_ring: got %h alarm=%b want 072959 0000", now_t, alarm);
        end
        cyc(4);
        n_vec++;
        if (now_t !== 24'h073000 || alarm !== 4'b0100 || alarm_any !== 1'b1) begin
            n_err++; $display("FAIL ring_start: got %h alarm=%b any=%b want 073000 0100 1", now_t, alarm, alarm_any);
        end
        cyc(11);
        n_vec++;
        if (alarm !== 4'b0100) begin n_err++; $display("FAIL ring_hold: got %b want 0100", alarm); end
        cyc(1);
        n_vec++;
        if (now_t !== 24'h073003 || alarm !== 4'b0000 || alarm_any !== 1'b0) begin
            n_err++; $display("FAIL ring_timeout: got %h alarm=%b any=%b want 073003 0000 0", now_t, alarm, alarm_any);
        end
    endtask

    task automatic test_stop;
        load_alarm(2'd0, 16'h0600);
        load_alarm(2'd3, 16'h0600);
        load_time(16'h0559);
        cyc(4 * 60);
        n_vec++;
        if (now_t !== 24'h060000 || alarm !== 4'b1001) begin
            n_err++; $display("FAIL dual_ring: got %h alarm=%b want 060000 1001", now_t, alarm);
        end
        STOP_al = 1'b1;
        cyc(1);
        STOP_al = 1'b0;
        n_vec++;
        if (alarm !== 4'b0000 || alarm_any !== 1'b0) begin
            n_err++; $display("FAIL stop: got alarm=%b any=%b want 0000 0", alarm, alarm_any);
        end
        load_time(16'h0559);
        cyc(4 * 60);
        n_vec++;
        if (alarm !== 4'b1001) begin n_err++; $display("FAIL rearmed: got %b want 1001", alarm); end
        clr_alarm(2'd3);
        n_vec++;
        if (alarm !== 4'b0001) begin n_err++; $display("FAIL clr_ringing: got %b want 0001", alarm); end
        STOP_al = 1'b1;
        cyc(1);
        STOP_al = 1'b0;
        n_vec++;
        if (alarm !== 4'b0000) begin n_err++; $display("FAIL stop_single: got %b want 0000", alarm); end
    endtask

    task automatic test_load_match;
        load_alarm(2'd1, 16'h0730);
        load_time(16'h0730);
        n_vec++;
        if (now_t !== 24'h073000 || alarm !== 4'b0000) begin
            n_err++; $display("FAIL load_no_ring: got %h alarm=%b want 073000 0000", now_t, alarm);
        end
        cyc(4);
        n_vec++;
        if (now_t !== 24'h073001 || alarm !== 4'b0000) begin
            n_err++; $display("FAIL after_load: got %h alarm=%b want 073001 0000", now_t, alarm);
        end
        set_hm(16'h2400);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
        n_vec++;
        if (now_t !== 24'h073001) begin n_err++; $display("FAIL bad_hour: got %h want %h", now_t, 24'h073001); end
        set_hm(16'h0775);
        LD_time = 1'b1;
        cyc(1);
        LD_time = 1'b0;
        n_vec++;
        if (now_t !== 24'h073001) begin n_err++; $display("FAIL bad_min: got %h want %h", now_t, 24'h073001); end
        cyc(2);
        n_vec++;
        if (now_t !== 24'h073002) begin n_err++; $display("FAIL prescale_kept: got %h want %h", now_t, 24'h073002); end
        clr_alarm(2'd1);
    endtask

    task automatic test_snooze;
        load_time(16'h0559);
        cyc(4 * 60);
        n_vec++;
        if (alarm !== 4'b0001) begin n_err++; $display("FAIL snz_ring: got %b want 0001", alarm); end
        SNOOZE = 1'b1;
        cyc(1);
        SNOOZE = 1'b0;
`ifdef ALARM_SNOOZE_EN
        n_vec++;
        if (alarm !== 4'b0000) begin n_err++; $display("FAIL snz_quiet: got %b want 0000", alarm); end
        cyc(235);
        n_vec++;
        if (alarm !== 4'b0000) begin n_err++; $display("FAIL snz_59: got %b want 0000", alarm); end
        cyc(4);
        n_vec++;
        if (alarm !== 4'b0001 || now_t !== 24'h060100) begin
            n_err++; $display("FAIL snz_rering: got alarm=%b %h want 0001 060100", alarm, now_t);
        end
        cyc(12);
        n_vec++;
        if (alarm !== 4'b0000) begin n_err++; $display("FAIL snz_timeout: got %b want 0000", alarm); end
`else
        n_vec++;
        if (alarm !== 4'b0001) begin n_err++; $display("FAIL snz_ignored: got %b want 0001", alarm); end
        cyc(11);
        n_vec++;
        if (alarm !== 4'b0000) begin n_err++; $display("FAIL nosnz_timeout: got %b want 0000", alarm); end
`endif
    endtask

    task automatic test_reset_mid_ring;
        load_time(16'h0729);
        cyc(4 * 60);
        n_vec++;
        if (alarm !== 4'b0100) begin n_err++; $display("FAIL pre_reset_ring: got %b want 0100", alarm); end
        reset = 1'b1;
        cyc(1);
        n_vec++;
        if (now_t !== 24'h000000 || alarm !== 4'b0000 || alarm_any !== 1'b0 || tick !== 1'b0) begin
            n_err++; $display("FAIL reset_mid_ring: got %h alarm=%b any=%b tick=%b want 000000 0000 0 0",
                              now_t, alarm, alarm_any, tick);
        end
        reset = 1'b0;
        load_time(16'h0729);
        cyc(4 * 60);
        n_vec++;
        if (now_t !== 24'h073000 || alarm !== 4'b0000) begin
            n_err++; $display("FAIL disarmed_by_reset: got %h alarm=%b want 073000 0000", now_t, alarm);
        end
    endtask

    task automatic test_clr_priority;
        set_hm(16'h0001);
        AL_sel   = 2'd1;
        LD_alarm = 1'b1;
        AL_clr   = 1'b1;
        cyc(1);
        LD_alarm = 1'b0;
        AL_clr   = 1'b0;
        load_time(16'h0000);
        cyc(4 * 60);
        n_vec++;
        if (now_t !== 24'h000100 || alarm !== 4'b0000) begin
            n_err++; $display("FAIL clr_beats_ld: got %h alarm=%b want 000100 0000", now_t, alarm);
        end
        load_alarm(2'd1, 16'h0001);
        load_time(16'h0000);
        cyc(4 * 60);
        n_vec++;
        if (alarm !== 4'b0010) begin n_err++; $display("FAIL ld_alone: got %b want 0010", alarm); end
    endtask

    initial begin
        reset    = 1'b1;
        H_in1    = 2'd0;
        H_in0    = 4'd0;
        M_in1    = 4'd0;
        M_in0    = 4'd0;
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        AL_sel   = 2'd0;
        AL_clr   = 1'b0;
        STOP_al  = 1'b0;
        SNOOZE   = 1'b0;
        test_reset();
        test_rollover();
        test_alarm_ring();
        test_stop();
        test_load_match();
        test_snooze();
        test_reset_mid_ring();
        test_clr_priority();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
